conv_8_4_ctrl: RTL and testbench

// Sequencer for the 8-sample x / 4-tap f convolution datapath (x memory, f memory, MAC accumulator).

---
 rtl/conv_pkg.sv | 9 +
 rtl/conv_load_port.sv | 35 +++
 rtl/conv_8_4_ctrl.sv | 97 +++++++++
 tb/tb_conv_8_4_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the 8-sample x / 4-tap f convolution sequencer.
package conv_pkg;
  localparam int N    = 8;
  localparam int M    = 4;
  localparam int LOGN = 3;
  localparam int LOGM = 2;

  typedef enum logic [1:0] {LOAD, MAC, DRAIN, OUT} state_t;
endpackage

// File: rtl/conv_load_port.sv
// Valid/ready load port: write counter that drives the memory write address and saturates at DEPTH.
module conv_load_port #(
  parameter int DEPTH = 8,
  parameter int LOGD  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic            wr_en_o,
  output logic [LOGD-1:0] addr_o,
  output logic            full_o
);
  logic [LOGD:0] cnt_q, cnt_d;

  assign ready_o = en_i && (cnt_q < (LOGD+1)'(DEPTH));
  assign wr_en_o = valid_i && ready_o;
  assign addr_o  = cnt_q[LOGD-1:0];

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)        cnt_d = '0;
    else if (wr_en_o) cnt_d = cnt_q + 1'b1;
  end

  // Full as of the coming edge, so a final write can release the sequencer on the same edge.
  assign full_o = (cnt_d == (LOGD+1)'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/conv_8_4_ctrl.sv
// Convolution sequencer: loads x and f through slave ports, then walks N-M+1 windows of M MACs,
// presenting each accumulator result on a valid/ready master port.
module conv_8_4_ctrl
  import conv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid_x,
  output logic            s_ready_x,
  input  logic            s_valid_f,
  output logic            s_ready_f,
  output logic [LOGN-1:0] addr_x,
  output logic            wr_en_x,
  output logic [LOGM-1:0] addr_f,
  output logic            wr_en_f,
  output logic            en_acc,
  output logic            clr_acc,
  output logic            m_valid_y,
  input  logic            m_ready_y,
  output logic            conv_done
);
  state_t          state_q, state_d;
  logic [LOGM-1:0] tap_q, tap_d;
  logic [LOGN-1:0] win_q, win_d;
  logic            en_acc_q;

  logic            load, hs, last_win, frame_end;
  logic            x_full, f_full;
  logic [LOGN-1:0] x_waddr;
  logic [LOGM-1:0] f_waddr;

  assign load      = (state_q == LOAD);
  assign hs        = (state_q == OUT) && m_ready_y;
  assign last_win  = (win_q == LOGN'(N - M));
  assign frame_end = hs && last_win;

  conv_load_port #(.DEPTH(N), .LOGD(LOGN)) u_x_port (
    .clk(clk), .reset(reset), .en_i(load), .clr_i(frame_end), .valid_i(s_valid_x),
    .ready_o(s_ready_x), .wr_en_o(wr_en_x), .addr_o(x_waddr), .full_o(x_full)
  );

  conv_load_port #(.DEPTH(M), .LOGD(LOGM)) u_f_port (
    .clk(clk), .reset(reset), .en_i(load), .clr_i(frame_end), .valid_i(s_valid_f),
    .ready_o(s_ready_f), .wr_en_o(wr_en_f), .addr_o(f_waddr), .full_o(f_full)
  );

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    win_d   = win_q;
    case (state_q)
      LOAD: if (x_full && f_full) begin
        state_d = MAC;
        tap_d   = '0;
        win_d   = '0;
      end
      MAC: begin
        if (tap_q == LOGM'(M - 1)) state_d = DRAIN;
        else                       tap_d   = tap_q + 1'b1;
      end
      DRAIN: state_d = OUT;
      OUT: if (m_ready_y) begin
        tap_d = '0;
        if (last_win) begin
          state_d = LOAD;
          win_d   = '0;
        end else begin
          state_d = MAC;
          win_d   = win_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // en_acc lags each MAC address cycle by one to match the memory read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      tap_q    <= '0;
      win_q    <= '0;
      en_acc_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      win_q    <= win_d;
      en_acc_q <= (state_q == MAC);
    end
  end

  assign addr_x    = load ? x_waddr : (win_q + LOGN'(tap_q));
  assign addr_f    = load ? f_waddr : tap_q;
  assign en_acc    = en_acc_q;
  assign clr_acc   = load || hs;
  assign m_valid_y = (state_q == OUT);
  assign conv_done = frame_end;
endmodule

// File: tb/tb_conv_8_4_ctrl.sv
// Bench for conv_8_4_ctrl: models x/f memories and accumulator around the sequencer and
// compares every output window against a direct convolution of the loaded frame.
module tb_conv_8_4_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid_x = 1'b0, s_valid_f = 1'b0, m_ready_y = 1'b0;
  logic       s_ready_x, s_ready_f, wr_en_x, wr_en_f, en_acc, clr_acc, m_valid_y, conv_done;
  logic [2:0] addr_x;
  logic [1:0] addr_f;
  logic [7:0] x_data = '0, f_data = '0;

  always #5 clk = ~clk;

  conv_8_4_ctrl dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .addr_x(addr_x), .wr_en_x(wr_en_x), .addr_f(addr_f), .wr_en_f(wr_en_f),
    .en_acc(en_acc), .clr_acc(clr_acc),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y), .conv_done(conv_done)
  );

  // external datapath: memories with 1-cycle read, MAC accumulator
  logic [7:0]  xmem [8];
  logic [7:0]  fmem [4];
  logic [7:0]  rd_x = '0, rd_f = '0;
  logic [31:0] acc = '0;
  initial begin
    for (int i = 0; i < 8; i++) xmem[i] = '0;
    for (int i = 0; i < 4; i++) fmem[i] = '0;
  end
  always @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= x_data;
    if (wr_en_f) fmem[addr_f] <= f_data;
    rd_x <= xmem[addr_x];
    rd_f <= fmem[addr_f];
    if (clr_acc)     acc <= '0;
    else if (en_acc) acc <= acc + rd_x * rd_f;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int y_q[$];
  int done_cnt = 0, ovl_cnt = 0;
  always @(negedge clk) if (!reset) begin
    if (m_valid_y && m_ready_y) y_q.push_back(int'(acc));
    if (conv_done) done_cnt++;
    if (en_acc && clr_acc) ovl_cnt++;
  end

  int total = 0, bad = 0;

  // reference frame
  logic [7:0] xs [8];
  logic [7:0] fs [4];
  function automatic int yexp(int j);
    int s = 0;
    for (int k = 0; k < 4; k++) s += int'(xs[j+k]) * int'(fs[k]);
    return s;
  endfunction

  task automatic rand_frame();
    for (int i = 0; i < 8; i++) xs[i] = 8'($urandom_range(255));
    for (int i = 0; i < 4; i++) fs[i] = 8'($urandom_range(15));
  endtask

  task automatic step();
    @(posedge clk); #1;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_frame(input int gx, input int gf, input int x0, input int f0,
                            output int t_last);
    int xi, fi, n;
    xi = x0; fi = f0; n = 0;
    while ((xi < 8 || fi < 4) && n < 400) begin
      @(posedge clk); #1;
      s_valid_x = (xi < 8) && ($urandom_range(99) >= gx);
      s_valid_f = (fi < 4) && ($urandom_range(99) >= gf);
      x_data = xs[(xi < 8) ? xi : 7];
      f_data = fs[(fi < 4) ? fi : 3];
      @(negedge clk);
      if (s_valid_x && s_ready_x) xi++;
      if (s_valid_f && s_ready_f) fi++;
      n++;
    end
    t_last = int'(cyc);
    if (n >= 400) begin
      total++; bad++;
      $display("FAIL load_timeout got x=%0d f=%0d want x=8 f=4", xi, fi);
    end
  endtask

  task automatic run_out(input int rdy_pct, input int max_cyc);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < max_cyc) begin
      @(posedge clk); #1;
      s_valid_x = 1'b0; s_valid_f = 1'b0;
      m_ready_y = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      n++;
    end
    step();
  endtask

  task automatic test_reset();
    logic [7:0] got;
    repeat (2) @(negedge clk);
    got = {s_ready_x, s_ready_f, clr_acc, en_acc, m_valid_y, wr_en_x, wr_en_f, conv_done};
    total++;
    if (got !== 8'b1110_0000 || addr_x !== 3'd0 || addr_f !== 2'd0) begin
      bad++; $display("FAIL reset_outputs got=%b ax=%0d af=%0d want=11100000 ax=0 af=0", got, addr_x, addr_f);
    end
    reset = 1'b0;
    step();
    got = {s_ready_x, s_ready_f, clr_acc, en_acc, m_valid_y, wr_en_x, wr_en_f, conv_done};
    total++;
    if (got !== 8'b1110_0000) begin
      bad++; $display("FAIL reset_idle got=%b want=11100000", got);
    end
  endtask

  task automatic test_basic();
    int t, d0;
    logic [3:0] gotf, expf;
    for (int i = 0; i < 8; i++) xs[i] = 8'(i + 1);
    for (int i = 0; i < 4; i++) fs[i] = 8'd1;
    y_q.delete(); d0 = done_cnt; m_ready_y = 1'b1;
    load_frame(0, 0, 0, 0, t);
    for (int j = 0; j < 5; j++)
      for (int c = 0; c < 6; c++) begin
        step();
        gotf = {m_valid_y, en_acc, clr_acc, conv_done};
        expf = {c == 5, (c >= 1 && c <= 4), c == 5, (c == 5 && j == 4)};
        total++;
        if (gotf !== expf || (c < 4 && (addr_x !== 3'(j + c) || addr_f !== 2'(c)))) begin
          bad++;
          $display("FAIL trace_w%0d_c%0d got vld/en/clr/done=%b ax=%0d af=%0d want=%b ax=%0d af=%0d",
                   j, c, gotf, addr_x, addr_f, expf, j + c, c);
        end
      end
    total++;
    if (int'(cyc) - t != 30) begin
      bad++; $display("FAIL basic_cycles got=%0d want=30", int'(cyc) - t);
    end
    step(); step();
    for (int j = 0; j < 5; j++) begin
      total++;
      if (j >= y_q.size() || y_q[j] != 10 + 4 * j) begin
        bad++; $display("FAIL basic_y%0d got=%0d want=%0d", j, (j < y_q.size()) ? y_q[j] : -1, 10 + 4 * j);
      end
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL basic_done got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_stall();
    int t, n, d0;
    logic [2:0] ax;
    logic [1:0] af;
    rand_frame(); y_q.delete(); d0 = done_cnt; m_ready_y = 1'b0;
    load_frame(20, 20, 0, 0, t);
    n = 0;
    while (!m_valid_y && n < 20) begin step(); n++; end
    total++;
    if (!m_valid_y || int'(cyc) - t != 6) begin
      bad++; $display("FAIL stall_latency got vld=%b dt=%0d want vld=1 dt=6", m_valid_y, int'(cyc) - t);
    end
    ax = addr_x; af = addr_f;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (m_valid_y !== 1'b1 || en_acc !== 1'b0 || conv_done !== 1'b0 || addr_x !== ax || addr_f !== af) begin
        bad++;
        $display("FAIL stall_hold%0d got vld=%b en=%b ax=%0d af=%0d want vld=1 en=0 ax=%0d af=%0d",
                 c, m_valid_y, en_acc, addr_x, addr_f, ax, af);
      end
    end
    run_out(60, 400);
    for (int j = 0; j < 5; j++) begin
      total++;
      if (j >= y_q.size() || y_q[j] != yexp(j)) begin
        bad++; $display("FAIL stall_y%0d got=%0d want=%0d", j, (j < y_q.size()) ? y_q[j] : -1, yexp(j));
      end
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL stall_done got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_gaps_overflow();
    int t, xi, n, d0;
    // x with gaps, f finished first
    rand_frame(); y_q.delete(); m_ready_y = 1'b1;
    load_frame(60, 0, 0, 0, t);
    run_out(70, 400);
    for (int j = 0; j < 5; j++) begin
      total++;
      if (j >= y_q.size() || y_q[j] != yexp(j)) begin
        bad++; $display("FAIL gaps_y%0d got=%0d want=%0d", j, (j < y_q.size()) ? y_q[j] : -1, yexp(j));
      end
    end
    // x full, f withheld, a 9th x held valid
    rand_frame(); y_q.delete(); d0 = done_cnt; xi = 0; n = 0;
    while (xi < 8 && n < 200) begin
      @(posedge clk); #1;
      s_valid_x = ($urandom_range(99) >= 40); s_valid_f = 1'b0; x_data = xs[xi];
      @(negedge clk);
      if (s_valid_x && s_ready_x) xi++;
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      s_valid_x = 1'b1; x_data = 8'hEE;
      @(negedge clk);
      total++;
      if (s_ready_x !== 1'b0 || wr_en_x !== 1'b0 || en_acc !== 1'b0 || clr_acc !== 1'b1 || s_ready_f !== 1'b1) begin
        bad++;
        $display("FAIL overflow_c%0d got rdyx=%b wrx=%b en=%b clr=%b rdyf=%b want 0 0 0 1 1",
                 c, s_ready_x, wr_en_x, en_acc, clr_acc, s_ready_f);
      end
    end
    load_frame(100, 30, 8, 0, t);
    run_out(100, 200);
    for (int j = 0; j < 5; j++) begin
      total++;
      if (j >= y_q.size() || y_q[j] != yexp(j)) begin
        bad++; $display("FAIL overflow_y%0d got=%0d want=%0d", j, (j < y_q.size()) ? y_q[j] : -1, yexp(j));
      end
    end
    total++;
    if (done_cnt - d0 != 1) begin
      bad++; $display("FAIL overflow_done got=%0d want=1", done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    logic [7:0] got;
    rand_frame(); y_q.delete(); m_ready_y = 1'b1;
    load_frame(0, 0, 0, 0, t);
    repeat (14) step();
    total++;
    if (y_q.size() != 2 || y_q[0] != yexp(0) || y_q[1] != yexp(1)) begin
      bad++; $display("FAIL midrst_partial got n=%0d want n=2 y0=%0d y1=%0d", y_q.size(), yexp(0), yexp(1));
    end
    #2 reset = 1'b1;
    #1;
    got = {s_ready_x, s_ready_f, clr_acc, en_acc, m_valid_y, wr_en_x, wr_en_f, conv_done};
    total++;
    if (got !== 8'b1110_0000 || addr_x !== 3'd0 || addr_f !== 2'd0) begin
      bad++; $display("FAIL midrst_async got=%b ax=%0d af=%0d want=11100000 ax=0 af=0", got, addr_x, addr_f);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rand_frame(); y_q.delete();
    load_frame(30, 30, 0, 0, t);
    run_out(80, 400);
    for (int j = 0; j < 5; j++) begin
      total++;
      if (j >= y_q.size() || y_q[j] != yexp(j)) begin
        bad++; $display("FAIL midrst_y%0d got=%0d want=%0d", j, (j < y_q.size()) ? y_q[j] : -1, yexp(j));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t, d0;
    rand_frame();
    for (int fr = 0; fr < 2; fr++) begin
      if (fr == 1) for (int i = 0; i < 4; i++) fs[i] = 8'(fs[i] + 1 + $urandom_range(7));
      y_q.delete(); d0 = done_cnt; m_ready_y = 1'b1;
      load_frame(0, 0, 0, 0, t);
      run_out(100, 100);
      for (int j = 0; j < 5; j++) begin
        total++;
        if (j >= y_q.size() || y_q[j] != yexp(j)) begin
          bad++; $display("FAIL b2b%0d_y%0d got=%0d want=%0d", fr, j, (j < y_q.size()) ? y_q[j] : -1, yexp(j));
        end
      end
      total++;
      if (done_cnt - d0 != 1) begin
        bad++; $display("FAIL b2b%0d_done got=%0d want=1", fr, done_cnt - d0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps_overflow();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (ovl_cnt != 0) begin
      bad++; $display("FAIL en_clr_overlap got=%0d want=0", ovl_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
